shift_chain_bist: RTL and testbench

//  Built-in self-test driver/checker for the serial shift-register delay chain.

---
 rtl/chain_pkg.sv | 22 ++
 rtl/prbs7_gen.sv | 29 ++
 rtl/shift_chain_bist.sv | 153 +++++++++++++++
 tb/tb_shift_chain_bist.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// Shared definitions for the shift-chain BIST: state encoding, PRBS7 polynomial,
// default chain depth and the replacement used for an all-zero seed.
package chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // x^7 + x^6 + 1: feedback taps on bits 6 and 5
  localparam logic [6:0] PRBS7_TAPS       = 7'b110_0000;
  localparam int         DEFAULT_LENGTH   = 256;
  localparam logic [6:0] SEED_REPLACEMENT = 7'h01;

  // One PRBS7 step: shift left, feed the tap parity into bit 0
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 generator with seed load; the output bit is the MSB of the state.
// An all-zero seed would lock the LFSR, so it is replaced on load.
module prbs7_gen
  import chain_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic       prbs_bit
);

  logic [6:0] state_q;

  // LFSR register: load has priority over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_REPLACEMENT;
    end else if (load) begin
      state_q <= (seed == 7'h00) ? SEED_REPLACEMENT : seed;
    end else if (advance) begin
      state_q <= prbs7_next(state_q);
    end
  end

  assign prbs_bit = state_q[6];

endmodule

// File: rtl/shift_chain_bist.sv
// BIST driver/checker for a serial shift-register delay chain. A generator LFSR
// drives the chain; a second LFSR started from the same seed but only advanced
// once data returns predicts the chain output bit by bit.
module shift_chain_bist
  import chain_pkg::*;
#(
  parameter int LENGTH    = DEFAULT_LENGTH,
  parameter int EXTRA_LAT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       seed,
  input  logic [CNT_W-1:0] test_len,
  input  logic             inject_err,
  input  logic             chain_dout,
  output logic             chain_din,
  output logic             chain_clken,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  // FILL must push a full chain depth plus any return-path registers before
  // the first returned bit is meaningful
  localparam int               FILL_CYCLES = LENGTH + EXTRA_LAT;
  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(FILL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             load;
  logic             gen_adv;
  logic             chk_adv;
  logic             gen_bit;
  logic             chk_bit;

  prbs7_gen u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .seed     (seed),
    .advance  (gen_adv),
    .prbs_bit (gen_bit)
  );

  prbs7_gen u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .seed     (seed),
    .advance  (chk_adv),
    .prbs_bit (chk_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and LFSR control
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    gen_adv = 1'b0;
    chk_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        gen_adv = 1'b1;
        if (cnt_q == FILL_LAST) begin
          state_d = (len_q == '0) ? ST_DONE : ST_CHECK;
        end
      end
      ST_CHECK: begin
        gen_adv = 1'b1;
        chk_adv = 1'b1;
        if (cnt_q == len_q - CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit counter, compare bookkeeping and the registered done/pass result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      len_q         <= '0;
      err_count     <= 8'h00;
      first_err_idx <= '1;
      pass          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q         <= '0;
            len_q         <= test_len;
            err_count     <= 8'h00;
            first_err_idx <= '1;
            pass          <= 1'b0;
          end
        end
        ST_FILL: begin
          cnt_q <= (cnt_q == FILL_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        ST_CHECK: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (chain_dout != chk_bit) begin
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            if (err_count == 8'h00) begin
              first_err_idx <= cnt_q;
            end
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          pass <= (err_count == 8'h00);
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign busy        = (state_q == ST_FILL) || (state_q == ST_CHECK);
  assign chain_clken = busy;
  assign chain_din   = busy & (gen_bit ^ inject_err);

endmodule

// File: tb/tb_shift_chain_bist.sv
// Self-checking bench: two BIST instances (direct loopback and two extra return
// registers) each wrapped around a behavioural shift-chain model.
module tb_shift_chain_bist;

  localparam int LENGTH = 256;
  localparam int CNT_W  = 16;
  localparam int LIMIT  = 4000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start0, start1;
  logic [6:0]       seed;
  logic [CNT_W-1:0] test_len;
  logic             inject_err;
  logic             stuck0;

  logic             dout0, din0, clken0, busy0, done0, pass0;
  logic [7:0]       err0;
  logic [CNT_W-1:0] first0;
  logic             dout1, din1, clken1, busy1, done1, pass1;
  logic [7:0]       err1;
  logic [CNT_W-1:0] first1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_chain_bist #(.LENGTH(LENGTH), .EXTRA_LAT(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed), .test_len(test_len),
    .inject_err(inject_err), .chain_dout(dout0), .chain_din(din0),
    .chain_clken(clken0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_idx(first0)
  );

  shift_chain_bist #(.LENGTH(LENGTH), .EXTRA_LAT(2), .CNT_W(CNT_W)) dut_lat (
    .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed), .test_len(test_len),
    .inject_err(inject_err), .chain_dout(dout1), .chain_din(din1),
    .chain_clken(clken1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_idx(first1)
  );

  // Chain models: plain shift registers, never reset; the second has two
  // always-enabled return registers behind it
  logic [LENGTH-1:0] chain0, chain1;
  logic              lat_a, lat_b;

  always @(posedge clk) begin
    if (clken0) chain0 <= {chain0[LENGTH-2:0], din0};
    if (clken1) chain1 <= {chain1[LENGTH-2:0], din1};
    lat_a <= chain1[LENGTH-1];
    lat_b <= lat_a;
  end

  assign dout0 = stuck0 ? 1'b0 : chain0[LENGTH-1];
  assign dout1 = lat_b;

  // Record every bit the DUTs push into their chains
  bit driven0[$];
  bit driven1[$];

  always @(posedge clk) begin
    if (clken0) driven0.push_back(din0);
    if (clken1) driven1.push_back(din1);
  end

  // Reference PRBS7 stream from the sequence recurrence b[n+7] = b[n] ^ b[n+1],
  // with the first seven bits being the seed read MSB first
  bit ref_bits[$];

  task automatic buildRef(input logic [6:0] sd, input int n);
    logic [6:0] s;
    s = (sd == 7'h00) ? 7'h01 : sd;
    ref_bits.delete();
    for (int i = 0; i < 7; i++) ref_bits.push_back(s[6-i]);
    for (int i = 7; i < n; i++) ref_bits.push_back(ref_bits[i-7] ^ ref_bits[i-6]);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Start a run on one instance and follow it cycle by cycle; optional inject
  // pulse, stray start pulse and mid-run reset at given cycle numbers
  task automatic applyStimulus(input bit which, input logic [6:0] sd,
                               input logic [CNT_W-1:0] len, input int inj_at,
                               input int start_at, input int rst_at,
                               output int cycles, output bit saw_done);
    seed       = sd;
    test_len   = len;
    inject_err = 1'b0;
    saw_done   = 1'b0;
    driven0.delete();
    driven1.delete();
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0     = 1'b0;
    start1     = 1'b0;
    cycles     = 0;
    inject_err = (inj_at == 0);
    while (cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
      inject_err = (cycles == inj_at);
      if (which) start1 = (cycles == start_at); else start0 = (cycles == start_at);
      if (cycles == rst_at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      if ((which ? done1 : done0) === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
    end
    inject_err = 1'b0;
    start0     = 1'b0;
    start1     = 1'b0;
  endtask

  // Compare a finished run with the expectation derived from the reference stream
  task automatic verifyRun(input bit which, input logic [6:0] sd,
                           input int len, input int inj_at, input bit stuck,
                           input int fill, input int cycles, input bit saw_done);
    int errs, first_exp, mism, o_size;
    bit ret, exp_bit, pass_exp;
    checkOutput("done_seen", 32'(saw_done), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(1 + fill + len));
    buildRef(sd, fill + len + 8);
    errs      = 0;
    first_exp = 16'hFFFF;
    for (int k = 0; k < len; k++) begin
      ret = stuck ? 1'b0 : (ref_bits[k] ^ (k == inj_at));
      if (ret != ref_bits[k]) begin
        if (errs == 0) first_exp = k;
        errs++;
      end
    end
    if (errs > 255) errs = 255;
    pass_exp = (errs == 0);
    checkOutput("err_count", 32'(which ? err1 : err0), 32'(errs));
    checkOutput("first_err_idx", 32'(which ? first1 : first0), 32'(first_exp));
    checkOutput("pass", 32'(which ? pass1 : pass0), 32'(pass_exp));
    checkOutput("clken_after_done", 32'(which ? clken1 : clken0), 32'd0);
    checkOutput("busy_after_done", 32'(which ? busy1 : busy0), 32'd0);
    o_size = which ? driven1.size() : driven0.size();
    checkOutput("stream_len", 32'(o_size), 32'(fill + len));
    mism = 0;
    for (int k = 0; k < o_size && k < fill + len; k++) begin
      exp_bit = ref_bits[k] ^ (k == inj_at);
      if ((which ? driven1[k] : driven0[k]) != exp_bit) mism++;
    end
    checkOutput("stream_bits", 32'(mism), 32'd0);
    @(posedge clk); #1;
    checkOutput("done_pulse", 32'(which ? done1 : done0), 32'd0);
    checkOutput("pass_held", 32'(which ? pass1 : pass0), 32'(pass_exp));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"},  32'(busy0),  32'd0);
    checkOutput({tag, "_clken"}, 32'(clken0), 32'd0);
    checkOutput({tag, "_din"},   32'(din0),   32'd0);
    checkOutput({tag, "_done"},  32'(done0),  32'd0);
    checkOutput({tag, "_pass"},  32'(pass0),  32'd0);
    checkOutput({tag, "_err"},   32'(err0),   32'd0);
    checkOutput({tag, "_first"}, 32'(first0), 32'hFFFF);
  endtask

  initial begin
    int         cycles;
    bit         saw;
    logic [6:0] sd;
    int         len, inj;

    rst_n      = 1'b1;
    start0     = 1'b0;
    start1     = 1'b0;
    seed       = 7'h00;
    test_len   = '0;
    inject_err = 1'b0;
    stuck0     = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checkResetValues("reset");
    checkOutput("reset_lat_clken", 32'(clken1), 32'd0);
    checkOutput("reset_lat_first", 32'(first1), 32'hFFFF);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] clean loopback, seed 01, 1000 compares");
    applyStimulus(1'b0, 7'h01, 16'd1000, -1, -1, -1, cycles, saw);
    verifyRun(1'b0, 7'h01, 1000, -1, 1'b0, LENGTH, cycles, saw);

    $display("[TB] single injected error on FILL cycle 5");
    applyStimulus(1'b0, 7'h5A, 16'd400, 5, -1, -1, cycles, saw);
    verifyRun(1'b0, 7'h5A, 400, 5, 1'b0, LENGTH, cycles, saw);

    $display("[TB] chain output stuck at 0, counter saturation");
    stuck0 = 1'b1;
    applyStimulus(1'b0, 7'h7F, 16'd600, -1, -1, -1, cycles, saw);
    verifyRun(1'b0, 7'h7F, 600, -1, 1'b1, LENGTH, cycles, saw);
    stuck0 = 1'b0;

    $display("[TB] zero seed, zero-length test");
    applyStimulus(1'b0, 7'h00, 16'd0, -1, -1, -1, cycles, saw);
    verifyRun(1'b0, 7'h00, 0, -1, 1'b0, LENGTH, cycles, saw);

    $display("[TB] reset asserted mid-CHECK");
    applyStimulus(1'b0, 7'($urandom), 16'd500, 3, -1, 300, cycles, saw);
    checkOutput("rst_mid_no_done", 32'(saw), 32'd0);
    checkResetValues("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] stray start while busy is ignored");
    sd = 7'($urandom);
    applyStimulus(1'b0, sd, 16'd200, -1, 50, -1, cycles, saw);
    verifyRun(1'b0, sd, 200, -1, 1'b0, LENGTH, cycles, saw);

    $display("[TB] two extra return registers");
    sd = 7'($urandom);
    applyStimulus(1'b1, sd, 16'd300, -1, -1, -1, cycles, saw);
    verifyRun(1'b1, sd, 300, -1, 1'b0, LENGTH + 2, cycles, saw);

    for (int r = 0; r < 3; r++) begin
      sd  = 7'($urandom);
      len = $urandom_range(1, 400);
      inj = $urandom_range(0, LENGTH - 1);
      $display("[TB] random run seed %0h len %0d inject %0d", sd, len, inj);
      applyStimulus(1'b0, sd, CNT_W'(len), inj, -1, -1, cycles, saw);
      verifyRun(1'b0, sd, len, inj, 1'b0, LENGTH, cycles, saw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
